lrf_frame_sequencer: RTL
========================

// Module: lrf_frame_sequencer
// PURPOSE
//  Upstream feeder for LRF. Reads stored frames from a fixed-latency word memory and emits
//  one AXI-Stream alternating each NEW frame k with its history frame, then zero flush beats.
//  Replaces the bench-side input controller in hardware; m_axis_* connects to LRF s_axis_*.
// PARAMETERS
//  PIXELS_PER_BEAT 16   pixels per beat; WORD_W = 8*PIXELS_PER_BEAT
//  IMAGE_DIM       512  frame side; WPI = IMAGE_DIM*IMAGE_DIM/PIXELS_PER_BEAT words/frame
//  N_FUSE_COUNT    4    HIST = 1<<N_FUSE_COUNT frame distance to the history frame
//  N_FRAMES        5    NEW frames per run
//  FLUSH_BEATS     10   trailing zero beats (= LRF PIPELINE_DELAY)
//  MEM_LATENCY     2    mem_ren to mem_rdata cycles, fixed, >=1
//  FIFO_DEPTH      8    output FIFO entries, >= MEM_LATENCY+2
//  ADDR_W          32   memory word-address width
// PORTS
//  s_axis_aclk    in  1       clock
//  s_axis_areset  in  1       synchronous reset, active-high
//  start          in  1       pulse: begin run (ignored while busy)
//  cfg_base_addr  in  ADDR_W  word address of frame 0; sampled on accepted start
//  busy           out 1       run in progress
//  done           out 1       one-cycle pulse after last flush beat handshakes
//  mem_ren        out 1       memory read strobe
//  mem_raddr      out ADDR_W  memory word address
//  mem_rdata      in  WORD_W  read data, valid MEM_LATENCY cycles after mem_ren
//  m_axis_tdata   out WORD_W  stream data
//  m_axis_tvalid  out 1       stream valid
//  m_axis_tready  in  1       stream ready
//  m_axis_tlast   out 1       last beat of each frame (never on flush beats)
//  m_axis_tuser   out 1       0 = NEW frame beat, 1 = history frame / flush beat
// BEHAVIOUR
//  Reset: all outputs 0; FSM IDLE; FIFO and issue pipeline emptied; in-flight reads dropped.
//  Reset mid-run aborts without done. mem_rdata arriving after reset is discarded.
//  FSM (issue side): IDLE -start-> NEW; NEW -beat WPI-1-> OLD; OLD -beat WPI-1-> NEW (k+1),
//   or FLUSH if k==N_FRAMES-1; FLUSH -FLUSH_BEATS issued-> DRAIN; DRAIN -FIFO and pipe
//   empty and last beat handshaken-> IDLE with done=1 that cycle. busy=1 in all but IDLE.
//  Frame index: NEW uses k; OLD uses h = (k>=HIST) ? k-HIST : 0.
//  Address: cfg_base_addr + frame*WPI + beat, modulo 2^ADDR_W.
//  Issue: one entry per cycle when (FIFO count + entries in pipe) < FIFO_DEPTH; never
//   overflows regardless of tready. NEW/OLD issues assert mem_ren; FLUSH issues do not.
//  Issue pipeline: MEM_LATENCY stages carry {valid,last,user,flush}; at the end the entry
//   writes FIFO with data = flush ? 0 : mem_rdata. Output order == issue order.
//  Stream: tdata/tlast/tuser from FIFO head; tvalid = FIFO not empty; pop on tvalid&tready.
//   Standard AXI: payload held stable while tvalid&!tready. Simultaneous push+pop allowed.
//  Latency: first beat tvalid no earlier than MEM_LATENCY+2 cycles after start (issue
//   in NEW's first cycle, pipe, FIFO write, registered head).
//  Throughput: 1 beat/cycle sustained when tready held 1.
//  Totals per run: 2*N_FRAMES*WPI data beats, 2*N_FRAMES tlast, FLUSH_BEATS zero beats.
//  start during busy: ignored, no effect on sequence.
// TESTING  (bench params: IMAGE_DIM=8, PIXELS_PER_BEAT=16 -> WPI=4, N_FUSE_COUNT=1 -> HIST=2,
//  N_FRAMES=4, FLUSH_BEATS=3, MEM_LATENCY=2; mem word = address)
//  1 start, base=0x100, tready=1 -> frame order 0,0,1,0,2,0,3,1; first beats 0x100..0x103
//    tuser=0, then 0x100..0x103 tuser=1; 32 data beats, 8 tlast, 3 zero beats, done once.
//  2 random tready (50%) -> identical beat sequence to test 1, no drop/duplicate, payload
//    stable while stalled, mem_ren never issued with FIFO+pipe count == FIFO_DEPTH.
//  3 tready=0 for 20 cycles after start -> exactly FIFO_DEPTH entries issued, then stall;
//    release -> sequence resumes at beat FIFO_DEPTH with no gap.
//  4 base=0xFFFF_FFF8 -> addresses wrap to 0x0000_0000 onward; no X or hang.
//  5 reset asserted at beat 13 -> next cycle tvalid=0, busy=0, mem_ren=0; fresh start
//    reproduces test 1 exactly; no done from aborted run.
//  6 start pulsed again at beat 5 -> ignored; output matches test 1; done after 35 beats.

Source files
------------

// File: rtl/lrf_frame_sequencer.sv
// Frame sequencer feeding LRF: NEW/history frame beats from a fixed-latency
// word memory, then zero flush beats, through an output FIFO.
module lrf_frame_sequencer #(
  parameter int PIXELS_PER_BEAT = 16,
  parameter int IMAGE_DIM       = 512,
  parameter int N_FUSE_COUNT    = 4,
  parameter int N_FRAMES        = 5,
  parameter int FLUSH_BEATS     = 10,
  parameter int MEM_LATENCY     = 2,
  parameter int FIFO_DEPTH      = 8,
  parameter int ADDR_W          = 32,
  localparam int WORD_W = 8 * PIXELS_PER_BEAT
) (
  input  logic              s_axis_aclk,
  input  logic              s_axis_areset,
  input  logic              start,
  input  logic [ADDR_W-1:0] cfg_base_addr,
  output logic              busy,
  output logic              done,
  output logic              mem_ren,
  output logic [ADDR_W-1:0] mem_raddr,
  input  logic [WORD_W-1:0] mem_rdata,
  output logic [WORD_W-1:0] m_axis_tdata,
  output logic              m_axis_tvalid,
  input  logic              m_axis_tready,
  output logic              m_axis_tlast,
  output logic              m_axis_tuser
);

  localparam int WPI =
    IMAGE_DIM * IMAGE_DIM / PIXELS_PER_BEAT;
  localparam int HIST = 1 << N_FUSE_COUNT;
  localparam int BMAX =
    (WPI > FLUSH_BEATS) ? WPI : FLUSH_BEATS;
  localparam int BEAT_W = $clog2(BMAX + 1);
  localparam int FRM_W = $clog2(N_FRAMES + 1);
  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W =
    $clog2(FIFO_DEPTH + MEM_LATENCY + 1) + 1;
  localparam int L = MEM_LATENCY;

  typedef enum logic [2:0] {
    S_IDLE,
    S_NEW,
    S_OLD,
    S_FLUSH,
    S_DRAIN
  } state_t;

  state_t state_q, state_d;
  logic [FRM_W-1:0]  k_q, k_d;
  logic [BEAT_W-1:0] beat_q, beat_d;
  logic [ADDR_W-1:0] base_q;
  logic              done_q;

  logic [L-1:0] pv_q, pl_q, pu_q, pf_q;

  logic [WORD_W-1:0] f_data [FIFO_DEPTH];
  logic [FIFO_DEPTH-1:0] f_last, f_user;
  logic [PTR_W-1:0] wr_q, rd_q;
  logic [CNT_W-1:0] cnt_q;

  logic [CNT_W-1:0] pipe_cnt;
  logic [CNT_W-1:0] occ;
  logic             gen_st;
  logic             issue;
  logic             rd_iss;
  logic             last_beat;
  logic             flush_last;
  logic             iss_last;
  logic             iss_user;
  logic             iss_flush;
  logic             push;
  logic             pop;
  logic             drain_exit;
  logic [31:0]      k_ext, h_ext, frm;
  logic [ADDR_W-1:0] addr;

  always_comb begin
    pipe_cnt = '0;
    for (int i = 0; i < L; i++) begin
      pipe_cnt = pipe_cnt + CNT_W'(pv_q[i]);
    end
  end

  assign occ = cnt_q + pipe_cnt;

  assign gen_st = (state_q == S_NEW) ||
                  (state_q == S_OLD) ||
                  (state_q == S_FLUSH);

  // Room is judged on committed entries only, so a
  // same-cycle pop never lets the FIFO overflow.
  assign issue = !s_axis_areset && gen_st &&
                 (occ < CNT_W'(FIFO_DEPTH));
  assign rd_iss = issue && (state_q != S_FLUSH);

  assign last_beat = beat_q == BEAT_W'(WPI - 1);
  assign flush_last =
    beat_q == BEAT_W'(FLUSH_BEATS - 1);

  assign iss_last = last_beat &&
                    (state_q != S_FLUSH);
  assign iss_user = state_q != S_NEW;
  assign iss_flush = state_q == S_FLUSH;

  always_comb begin
    k_ext = 32'(k_q);
    h_ext = '0;
    if (k_ext >= 32'(HIST)) begin
      h_ext = k_ext - 32'(HIST);
    end
    frm = (state_q == S_OLD) ? h_ext : k_ext;
    addr = base_q +
           ADDR_W'(frm) * ADDR_W'(WPI) +
           ADDR_W'(beat_q);
  end

  assign mem_ren = rd_iss;
  assign mem_raddr = rd_iss ? addr : '0;

  assign push = pv_q[L-1];
  assign pop = (cnt_q != '0) && m_axis_tready;

  assign drain_exit = (state_q == S_DRAIN) &&
                      pop &&
                      (cnt_q == CNT_W'(1)) &&
                      (pipe_cnt == '0);

  always_comb begin
    state_d = state_q;
    k_d = k_q;
    beat_d = beat_q;
    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_NEW;
          k_d = '0;
          beat_d = '0;
        end
      end
      S_NEW: begin
        if (issue) begin
          if (last_beat) begin
            beat_d = '0;
            state_d = S_OLD;
          end else begin
            beat_d = beat_q + BEAT_W'(1);
          end
        end
      end
      S_OLD: begin
        if (issue) begin
          if (last_beat) begin
            beat_d = '0;
            if (k_q == FRM_W'(N_FRAMES - 1)) begin
              state_d = S_FLUSH;
            end else begin
              k_d = k_q + FRM_W'(1);
              state_d = S_NEW;
            end
          end else begin
            beat_d = beat_q + BEAT_W'(1);
          end
        end
      end
      S_FLUSH: begin
        if (issue) begin
          if (flush_last) begin
            beat_d = '0;
            state_d = S_DRAIN;
          end else begin
            beat_d = beat_q + BEAT_W'(1);
          end
        end
      end
      S_DRAIN: begin
        if (drain_exit) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge s_axis_aclk) begin
    if (s_axis_areset) begin
      state_q <= S_IDLE;
      k_q <= '0;
      beat_q <= '0;
      base_q <= '0;
      done_q <= 1'b0;
    end else begin
      state_q <= state_d;
      k_q <= k_d;
      beat_q <= beat_d;
      done_q <= drain_exit;
      if (state_q == S_IDLE && start) begin
        base_q <= cfg_base_addr;
      end
    end
  end

  // Sideband travels beside the read so it meets its data.
  always_ff @(posedge s_axis_aclk) begin
    if (s_axis_areset) begin
      pv_q <= '0;
      pl_q <= '0;
      pu_q <= '0;
      pf_q <= '0;
    end else begin
      pv_q[0] <= issue;
      pl_q[0] <= iss_last;
      pu_q[0] <= iss_user;
      pf_q[0] <= iss_flush;
      for (int i = 1; i < L; i++) begin
        pv_q[i] <= pv_q[i-1];
        pl_q[i] <= pl_q[i-1];
        pu_q[i] <= pu_q[i-1];
        pf_q[i] <= pf_q[i-1];
      end
    end
  end

  always_ff @(posedge s_axis_aclk) begin
    if (s_axis_areset) begin
      wr_q <= '0;
      rd_q <= '0;
      cnt_q <= '0;
    end else begin
      if (push) begin
        wr_q <= (wr_q == PTR_W'(FIFO_DEPTH - 1)) ?
                '0 : wr_q + PTR_W'(1);
      end
      if (pop) begin
        rd_q <= (rd_q == PTR_W'(FIFO_DEPTH - 1)) ?
                '0 : rd_q + PTR_W'(1);
      end
      cnt_q <= cnt_q + CNT_W'(push) - CNT_W'(pop);
    end
  end

  always_ff @(posedge s_axis_aclk) begin
    if (push) begin
      f_data[wr_q] <= pf_q[L-1] ? '0 : mem_rdata;
      f_last[wr_q] <= pl_q[L-1];
      f_user[wr_q] <= pu_q[L-1];
    end
  end

  assign m_axis_tvalid = cnt_q != '0;
  assign m_axis_tdata =
    m_axis_tvalid ? f_data[rd_q] : '0;
  assign m_axis_tlast =
    m_axis_tvalid && f_last[rd_q];
  assign m_axis_tuser =
    m_axis_tvalid && f_user[rd_q];

  assign busy = state_q != S_IDLE;
  assign done = done_q;

endmodule
